// File: rtl/ciclo_lavagem_ctrl_if.sv
// Sensor/command inputs and actuator/status outputs of the wash-cycle sequencer.
// The master side feeds the commands and sensors; the slave side is the sequencer.
interface ciclo_lavagem_ctrl_if;
    logic       start;
    logic       door_closed;
    logic       water_full;
    logic       tick;
    logic [7:0] duracao_lavagem;
    logic [2:0] state;
    logic [7:0] remaining;
    logic       water_valve;
    logic       drain_pump;
    logic       motor_wash;
    logic       motor_spin;
    logic       door_lock;
    logic       done;
    logic       paused;
    logic       fault;

    modport master (
        output start, door_closed, water_full, tick, duracao_lavagem,
        input  state, remaining, water_valve, drain_pump,
        input  motor_wash, motor_spin, door_lock, done, paused, fault
    );

    modport slave (
        input  start, door_closed, water_full, tick, duracao_lavagem,
        output state, remaining, water_valve, drain_pump,
        output motor_wash, motor_spin, door_lock, done, paused, fault
    );
endinterface

// File: rtl/ciclo_lavagem_ctrl.sv
// Wash-cycle sequencer: fill, wash, drain and spin phases timed in ticks,
// with door-open pause/resume and a sticky fill-timeout fault.
module ciclo_lavagem_ctrl #(
    parameter int DRAIN_TIME   = 10,
    parameter int SPIN_TIME    = 20,
    parameter int FILL_TIMEOUT = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    ciclo_lavagem_ctrl_if.slave   bus
);
    localparam logic [7:0] DT = DRAIN_TIME[7:0];
    localparam logic [7:0] ST = SPIN_TIME[7:0];
    localparam logic [7:0] FT = FILL_TIMEOUT[7:0];

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_DRAIN = 3'd3,
        S_SPIN  = 3'd4,
        S_DONE  = 3'd5,
        S_PAUSE = 3'd6,
        S_ERROR = 3'd7
    } st_t;

    st_t        st, st_n;
    st_t        saved, saved_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] wash_len, len_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= S_IDLE;
            saved    <= S_IDLE;
            cnt      <= 8'd0;
            wash_len <= 8'd0;
        end else begin
            st       <= st_n;
            saved    <= saved_n;
            cnt      <= cnt_n;
            wash_len <= len_n;
        end
    end

    always_comb begin
        st_n    = st;
        saved_n = saved;
        cnt_n   = cnt;
        len_n   = wash_len;
        case (st)
            S_IDLE: begin
                if (bus.start && bus.door_closed) begin
                    len_n = bus.duracao_lavagem;
                    st_n  = S_FILL;
                    cnt_n = FT;
                end
            end
            S_FILL, S_WASH, S_DRAIN, S_SPIN: begin
                // door-open beats both water_full and phase completion
                if (!bus.door_closed) begin
                    st_n    = S_PAUSE;
                    saved_n = st;
                end else if (st == S_FILL && bus.water_full) begin
                    st_n  = S_WASH;
                    cnt_n = wash_len;
                end else if (cnt == 8'd0) begin
                    case (st)
                        S_FILL: st_n = S_ERROR;
                        S_WASH: begin
                            st_n  = S_DRAIN;
                            cnt_n = DT;
                        end
                        S_DRAIN: begin
                            st_n  = S_SPIN;
                            cnt_n = ST;
                        end
                        default: begin
                            st_n  = S_DONE;
                            cnt_n = 8'd0;
                        end
                    endcase
                end else if (bus.tick) begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_DONE: begin
                if (!bus.door_closed) st_n = S_IDLE;
            end
            S_PAUSE: begin
                if (bus.start && bus.door_closed) st_n = saved;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.water_valve = 1'b0;
        bus.drain_pump  = 1'b0;
        bus.motor_wash  = 1'b0;
        bus.motor_spin  = 1'b0;
        bus.door_lock   = 1'b0;
        bus.done        = 1'b0;
        bus.paused      = 1'b0;
        bus.fault       = 1'b0;
        case (st)
            S_FILL: begin
                bus.water_valve = 1'b1;
                bus.door_lock   = 1'b1;
            end
            S_WASH: begin
                bus.motor_wash = 1'b1;
                bus.door_lock  = 1'b1;
            end
            S_DRAIN: begin
                bus.drain_pump = 1'b1;
                bus.door_lock  = 1'b1;
            end
            S_SPIN: begin
                bus.motor_spin = 1'b1;
                bus.drain_pump = 1'b1;
                bus.door_lock  = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            S_PAUSE: bus.paused = 1'b1;
            S_ERROR: begin
                bus.fault      = 1'b1;
                bus.drain_pump = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state     = st;
    assign bus.remaining = cnt;
endmodule

// File: tb/tb_ciclo_lavagem_ctrl.sv
// Bench for ciclo_lavagem_ctrl: directed scenarios plus random stimulus
// compared every cycle against a phase-level reference model.
module tb_ciclo_lavagem_ctrl;
    localparam int FT  = 30;
    localparam int DT  = 10;
    localparam int STM = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ciclo_lavagem_ctrl_if bus ();

    ciclo_lavagem_ctrl #(
        .DRAIN_TIME  (DT),
        .SPIN_TIME   (STM),
        .FILL_TIMEOUT(FT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // expected actuator word per state:
    // {valve, pump, wash, spin, lock, done, paused, fault}
    logic [7:0] tbl [8] = '{8'h00, 8'h88, 8'h28, 8'h48,
                            8'h58, 8'h04, 8'h02, 8'h41};
    int nxt_st [5] = '{0, 7, 3, 4, 5};
    int nxt_ld [5] = '{0, 0, DT, STM, 0};

    int m_st = 0;
    int m_cnt = 0;
    int m_saved = 0;
    int m_len = 0;

    int len [8];
    int prev_st = 0;
    int run = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.water_valve, bus.drain_pump, bus.motor_wash,
                bus.motor_spin, bus.door_lock, bus.done,
                bus.paused, bus.fault};
    endfunction

    // reference model: phases with a countdown, pause remembers the phase
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = 0; m_cnt = 0; m_saved = 0; m_len = 0;
        end else begin
            case (m_st)
                0: if (bus.start && bus.door_closed) begin
                    m_len = bus.duracao_lavagem;
                    m_st = 1;
                    m_cnt = FT;
                end
                1, 2, 3, 4: begin
                    if (!bus.door_closed) begin
                        m_saved = m_st;
                        m_st = 6;
                    end else if (m_st == 1 && bus.water_full) begin
                        m_st = 2;
                        m_cnt = m_len;
                    end else if (m_cnt == 0) begin
                        m_cnt = nxt_ld[m_st];
                        m_st = nxt_st[m_st];
                    end else if (bus.tick) begin
                        m_cnt = m_cnt - 1;
                    end
                end
                5: if (!bus.door_closed) m_st = 0;
                6: if (bus.start && bus.door_closed) m_st = m_saved;
                default: ;
            endcase
        end
    end

    // compare process and phase-length tracker
    always @(negedge clk) begin
        if (!reset) begin
            chk("state", int'(bus.state), m_st);
            chk("remaining", int'(bus.remaining), m_cnt);
            chk("outputs", int'(outs()), int'(tbl[m_st]));
            if (int'(bus.state) != prev_st) begin
                len[prev_st] = run;
                run = 1;
                prev_st = int'(bus.state);
            end else begin
                run++;
            end
        end else begin
            prev_st = 0;
            run = 0;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic wait_st(input int s, input int maxc, input string nm);
        int k;
        k = 0;
        while (int'(bus.state) != s && k < maxc) begin
            cyc();
            k++;
        end
        chk(nm, int'(bus.state), s);
    endtask

    task automatic start_cycle(input int dur);
        bus.duracao_lavagem = 8'(dur);
        bus.door_closed = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("enter_fill", int'(bus.state), 1);
    endtask

    initial begin
        int k;
        bus.start = 1'b0;
        bus.door_closed = 1'b1;
        bus.water_full = 1'b0;
        bus.tick = 1'b1;
        bus.duracao_lavagem = 8'd0;
        cyc(2);
        chk("reset_state", int'(bus.state), 0);
        chk("reset_outs", int'(outs()), 0);
        reset = 1'b0;
        cyc();

        // normal cycle, water_full on 5th FILL clk
        start_cycle(60);
        cyc(4);
        bus.water_full = 1'b1;
        cyc();
        bus.water_full = 1'b0;
        chk("wash_entry_rem", int'(bus.remaining), 60);
        wait_st(5, 200, "reach_done");
        chk("fill_len", len[1], 5);
        chk("wash_len", len[2], 61);
        chk("drain_len", len[3], 11);
        chk("spin_len", len[4], 21);
        chk("done_flag", int'(bus.done), 1);
        bus.door_closed = 1'b0;
        cyc();
        chk("done_to_idle", int'(bus.state), 0);
        bus.door_closed = 1'b1;
        cyc();

        // latched duration
        start_cycle(100);
        cyc();
        bus.duracao_lavagem = 8'd60;
        bus.water_full = 1'b1;
        cyc();
        bus.water_full = 1'b0;
        chk("latch_rem", int'(bus.remaining), 100);
        wait_st(3, 200, "latch_drain");
        chk("latch_wash_len", len[2], 101);
        do_reset();

        // fill timeout
        start_cycle(5);
        wait_st(7, 100, "reach_error");
        chk("timeout_len", len[1], 31);
        chk("err_outs", int'(outs()), 8'h41);
        bus.start = 1'b1;
        cyc(3);
        bus.start = 1'b0;
        chk("error_sticky", int'(bus.state), 7);
        do_reset();

        // pause / resume at remaining 40
        start_cycle(60);
        bus.water_full = 1'b1;
        cyc();
        bus.water_full = 1'b0;
        k = 0;
        while (int'(bus.remaining) != 40 && k < 100) begin
            cyc();
            k++;
        end
        chk("reach_rem40", int'(bus.remaining), 40);
        bus.door_closed = 1'b0;
        cyc();
        chk("paused_state", int'(bus.state), 6);
        cyc(50);
        chk("pause_hold", int'(bus.remaining), 40);
        chk("pause_outs", int'(outs()), 8'h02);
        bus.door_closed = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("resume_state", int'(bus.state), 2);
        chk("resume_rem", int'(bus.remaining), 40);
        do_reset();

        // zero wash length
        start_cycle(0);
        bus.water_full = 1'b1;
        cyc();
        bus.water_full = 1'b0;
        wait_st(3, 10, "zero_drain");
        chk("zero_wash_len", len[2], 1);
        do_reset();

        // start with door open in IDLE
        bus.door_closed = 1'b0;
        bus.start = 1'b1;
        cyc(3);
        bus.start = 1'b0;
        bus.door_closed = 1'b1;
        chk("door_open_idle", int'(bus.state), 0);

        // water_full on the clk FILL cnt hits 0
        start_cycle(7);
        k = 0;
        while (int'(bus.remaining) != 0 && k < 100) begin
            cyc();
            k++;
        end
        bus.water_full = 1'b1;
        cyc();
        bus.water_full = 1'b0;
        chk("full_at_zero", int'(bus.state), 2);

        // async reset mid-SPIN
        wait_st(4, 100, "reach_spin");
        cyc(5);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("areset_state", int'(bus.state), 0);
        chk("areset_rem", int'(bus.remaining), 0);
        chk("areset_outs", int'(outs()), 0);
        cyc();
        reset = 1'b0;
        start_cycle(4);
        bus.water_full = 1'b1;
        cyc();
        bus.water_full = 1'b0;
        wait_st(5, 200, "rerun_done");
        chk("rerun_wash_len", len[2], 5);
        chk("rerun_spin_len", len[4], 21);

        // random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) do_reset();
            bus.tick = 1'($urandom_range(0, 1));
            bus.start = ($urandom_range(0, 9) < 2);
            bus.door_closed = ($urandom_range(0, 19) != 0);
            bus.water_full = ($urandom_range(0, 9) == 0);
            bus.duracao_lavagem = 8'($urandom_range(0, 15));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ciclo_lavagem_ctrl.md
Name: ciclo_lavagem_ctrl

Overview:
- Wash-cycle sequencer sitting directly downstream of the wash-duration selector.
- Latches the selected 8-bit wash duration at start and runs the machine through fill, wash, drain and spin phases, each timed in tick units.
- Drives the valve, pump, motor and door-lock actuators.
- Handles door-open pause/resume and a fill timeout fault.

Parameters:
- DRAIN_TIME, 10, drain phase length in ticks (1..255).
- SPIN_TIME, 20, spin phase length in ticks (1..255).
- FILL_TIMEOUT, 30, max ticks in FILL before fault (1..255).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  start/resume request, sampled per clk, level
- door_closed  input  1  door sensor, 1 = closed
- water_full  input  1  level sensor, 1 = drum full
- tick  input  1  one-clk pulse marking one time unit
- duracao_lavagem  input  8  wash duration in ticks, from the duration selector
- state  output  3  current FSM state code
- remaining  output  8  current phase countdown value
- water_valve  output  1  inlet valve on
- drain_pump  output  1  drain pump on
- motor_wash  output  1  low-speed wash motor on
- motor_spin  output  1  high-speed spin motor on
- door_lock  output  1  door lock engaged
- done  output  1  cycle finished
- paused  output  1  cycle suspended, door open
- fault  output  1  fill timeout fault

Behaviour:
- Reset (async, active-high): state = IDLE, cnt = 0, saved state = IDLE, wash_len = 0.
  - All outputs 0.
  - Reset mid-cycle aborts immediately; there is no resume after reset.
- State codes: IDLE=0, FILL=1, WASH=2, DRAIN=3, SPIN=4, DONE=5, PAUSE=6, ERROR=7.
- Moore outputs, decoded from the registered state:
  - FILL: water_valve=1, door_lock=1.
  - WASH: motor_wash=1, door_lock=1.
  - DRAIN: drain_pump=1, door_lock=1.
  - SPIN: motor_spin=1, drain_pump=1, door_lock=1.
  - DONE: done=1.
  - PAUSE: paused=1, all actuators 0, door_lock=0.
  - ERROR: fault=1, drain_pump=1, door_lock=0.
  - IDLE: all 0.
- remaining = cnt in every state.
- Phase counter rules:
  - cnt is loaded on the clk that enters a phase.
  - Within the phase it decrements by 1 on each clk where tick=1 and cnt≠0.
  - A timed phase exits on the first clk where cnt==0, so a phase of length N lasts N ticks plus at most 1 clk.
- IDLE:
  - If start=1 and door_closed=1: latch wash_len = duracao_lavagem, go to FILL, cnt = FILL_TIMEOUT.
  - If start=1 with the door open: no action.
  - Changes to duracao_lavagem after the latch have no effect on the current cycle.
- FILL:
  - water_full=1 → WASH, cnt = wash_len. water_full takes priority over a timeout in the same clk.
  - Otherwise, cnt==0 → ERROR.
- WASH: cnt==0 → DRAIN, cnt = DRAIN_TIME. If wash_len = 0, WASH lasts exactly 1 clk.
- DRAIN: cnt==0 → SPIN, cnt = SPIN_TIME.
- SPIN: cnt==0 → DONE, cnt = 0.
- DONE: holds until door_closed=0, then → IDLE.
- Door opened (door_closed=0) in FILL, WASH, DRAIN or SPIN:
  - Next state is PAUSE; the current state is saved and cnt is frozen.
  - Door-open takes priority over a phase completion in the same clk.
- PAUSE:
  - start=1 and door_closed=1 → return to the saved state with cnt unchanged (no reload).
  - tick is ignored while in PAUSE.
- ERROR: sticky; exits only via reset.
- Width rules:
  - All counters are 8-bit unsigned; decrement never wraps below 0.
  - Parameters are truncated to 8 bits.

Test Plan:
- Normal cycle, tick every clk, duracao_lavagem=60, water_full asserted on the 5th FILL clk → state sequence 1,2,3,4,5; WASH lasts 61 clk with motor_wash=1; DRAIN lasts 11 clk; SPIN lasts 21 clk; then done=1; opening the door → state 0.
- Latch check: start with duracao_lavagem=100, change it to 60 during FILL → remaining=100 on WASH entry; WASH lasts 101 clk.
- Fill timeout: water_full held 0, tick every clk → ERROR after 31 FILL clks with fault=1, drain_pump=1, door_lock=0; start has no effect until reset.
- Pause/resume: door opened when WASH remaining=40 → PAUSE, remaining holds 40 across 50 ticks, all actuators 0; door_closed=1 plus start=1 → WASH with remaining=40.
- Boundaries: duracao_lavagem=0 → WASH held for exactly 1 clk; start with door open in IDLE → stays in IDLE; water_full=1 on the same clk that FILL cnt reaches 0 → WASH, not ERROR.
- Async reset asserted mid-SPIN (not on a clk edge) → all outputs 0 and state=0 immediately; a new start runs a full cycle from FILL.
